// File: rtl/weight_bank_ctrl.sv
// Weight-BRAM controller for the MAC array. Streams words from the preload
// FIFO into BANK_NUM interleaved banks and reads back BANK_NUM-word bundles.
// Each bank is split into two regions so one layer loads while another reads.
module weight_bank_ctrl #(
  parameter int MAC_NUM            = 256,
  parameter int WORD_BITS          = 5,
  parameter int BANK_NUM           = 2,
  parameter int BRAM_ADDRESS_WIDTH = 12,
  parameter int READ_LATENCY       = 2,
  parameter int FIFO_CNT_WIDTH     = 3
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic [2:0]                                 kernel_size,
  input  logic [11:0]                                output_channel_size,
  input  logic                                       write_start,
  input  logic                                       write_abort,
  input  logic [FIFO_CNT_WIDTH-1:0]                  fifo_cnt,
  input  logic [MAC_NUM*WORD_BITS-1:0]               weight_from_preload,
  output logic                                       fifo_read,
  input  logic                                       rd_start,
  input  logic                                       rd_adv,
  input  logic [3:0]                                 rd_step,
  input  logic                                       layer_finish,
  input  logic [BANK_NUM*MAC_NUM*WORD_BITS-1:0]      bram_rdata,
  output logic [BANK_NUM*BRAM_ADDRESS_WIDTH-1:0]     bram_addr,
  output logic [BANK_NUM-1:0]                        bram_en,
  output logic [BANK_NUM-1:0]                        bram_wen,
  output logic [MAC_NUM*WORD_BITS-1:0]               bram_wdata,
  output logic [BANK_NUM*MAC_NUM*WORD_BITS-1:0]      weight_out,
  output logic                                       weight_out_valid,
  output logic                                       weights_ready,
  output logic                                       write_done,
  output logic                                       cfg_err
);

  localparam int          W   = MAC_NUM * WORD_BITS;
  localparam int          AW  = BRAM_ADDRESS_WIDTH;
  localparam int          IW  = AW - 1;
  localparam logic [31:0] BN  = 32'(BANK_NUM);
  localparam logic [31:0] CAP = BN << IW;
  localparam logic [2:0]  RL  = 3'(READ_LATENCY);

  typedef enum logic [1:0] {WIDLE, WWAIT, WREAD, WWRITE} wr_state_t;
  typedef enum logic [1:0] {RIDLE, RWAIT, RVALID} rd_state_t;

  wr_state_t      wr_state, wr_state_nxt;
  logic [14:0]    cnt, cnt_nxt, cnt_inc;
  logic [14:0]    total_q, total_nxt, total_w;
  logic           wr_region, wr_region_nxt;
  logic           wr_act, load_wdata, set_ready, done_nxt, cfg_err_nxt, cfg_bad;
  logic [31:0]    wr_bank;
  logic [IW-1:0]  wr_idx;

  rd_state_t      rd_state, rd_state_nxt;
  logic [15:0]    base, base_nxt;
  logic [2:0]     lat, lat_nxt;
  logic           rd_region, rd_region_nxt, rd_clear;
  logic [2:0]     base_lo;
  logic [2:0]     base_lo_p [READ_LATENCY];

  assign total_w = 15'(output_channel_size) * 15'(kernel_size);
  assign cfg_bad = (total_w == 15'd0) || (kernel_size > 3'd5) || ({17'd0, total_w} > CAP);
  assign cnt_inc = cnt + 15'd1;
  assign wr_bank = 32'(cnt) % BN;
  assign wr_idx  = IW'(32'(cnt) / BN);
  assign bram_en = '1;

  // Write FSM next state; abort overrides any FIFO pop or bank write this cycle.
  always_comb begin
    wr_state_nxt  = wr_state;
    cnt_nxt       = cnt;
    total_nxt     = total_q;
    wr_region_nxt = wr_region;
    fifo_read     = 1'b0;
    wr_act        = 1'b0;
    load_wdata    = 1'b0;
    set_ready     = 1'b0;
    done_nxt      = 1'b0;
    cfg_err_nxt   = 1'b0;
    if (write_abort) begin
      wr_state_nxt = WIDLE;
    end else begin
      case (wr_state)
        WIDLE: begin
          if (write_start) begin
            if (cfg_bad) begin
              cfg_err_nxt = 1'b1;
            end else begin
              wr_state_nxt = WWAIT;
              cnt_nxt      = 15'd0;
              total_nxt    = total_w;
            end
          end
        end
        WWAIT: begin
          if (fifo_cnt != '0) wr_state_nxt = WREAD;
        end
        WREAD: begin
          fifo_read    = 1'b1;
          load_wdata   = 1'b1;
          wr_state_nxt = WWRITE;
        end
        WWRITE: begin
          wr_act  = 1'b1;
          cnt_nxt = cnt_inc;
          if (cnt_inc == total_q) begin
            done_nxt      = 1'b1;
            wr_region_nxt = ~wr_region;
            set_ready     = 1'b1;
            wr_state_nxt  = WIDLE;
          end else begin
            wr_state_nxt = WWAIT;
          end
        end
        default: wr_state_nxt = WIDLE;
      endcase
    end
  end

  // Write FSM state, counters, pulses and the FIFO word holding register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_state   <= WIDLE;
      cnt        <= 15'd0;
      total_q    <= 15'd0;
      wr_region  <= 1'b0;
      write_done <= 1'b0;
      cfg_err    <= 1'b0;
      bram_wdata <= '0;
    end else begin
      wr_state   <= wr_state_nxt;
      cnt        <= cnt_nxt;
      total_q    <= total_nxt;
      wr_region  <= wr_region_nxt;
      write_done <= done_nxt;
      cfg_err    <= cfg_err_nxt;
      if (load_wdata) bram_wdata <= weight_from_preload;
    end
  end

  // Read FSM next state; layer_finish beats rd_start, which beats rd_adv.
  always_comb begin
    rd_state_nxt  = rd_state;
    base_nxt      = base;
    lat_nxt       = lat;
    rd_region_nxt = rd_region;
    rd_clear      = 1'b0;
    if (layer_finish) begin
      rd_state_nxt = RIDLE;
    end else if (rd_start) begin
      rd_state_nxt  = RWAIT;
      base_nxt      = 16'd0;
      lat_nxt       = RL;
      rd_region_nxt = ~wr_region;
      rd_clear      = 1'b1;
    end else begin
      case (rd_state)
        RWAIT: begin
          if (lat == 3'd0) rd_state_nxt = RVALID;
          else             lat_nxt = lat - 3'd1;
        end
        RVALID: begin
          if (rd_adv) begin
            base_nxt     = base + {12'd0, rd_step};
            lat_nxt      = RL;
            rd_state_nxt = RWAIT;
          end
        end
        default: ;
      endcase
    end
  end

  // Read FSM state and read pointer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_state  <= RIDLE;
      base      <= 16'd0;
      lat       <= 3'd0;
      rd_region <= 1'b0;
    end else begin
      rd_state  <= rd_state_nxt;
      base      <= base_nxt;
      lat       <= lat_nxt;
      rd_region <= rd_region_nxt;
    end
  end

  // weights_ready: set by a completed load, cleared when reading starts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            weights_ready <= 1'b0;
    else if (set_ready) weights_ready <= 1'b1;
    else if (rd_clear)  weights_ready <= 1'b0;
  end

  assign base_lo = 3'(32'(base) % BN);

  // Stage p0..pN: base low bits delayed to line up with BRAM read data.
  always_ff @(posedge clk) begin
    base_lo_p[0] <= base_lo;
    for (int i = 1; i < READ_LATENCY; i++) base_lo_p[i] <= base_lo_p[i-1];
  end

  assign weight_out_valid = (rd_state == RVALID);

  // Per-bank address: the bank being written takes the write address,
  // every other bank presents the word of the current bundle it holds.
  for (genvar b = 0; b < BANK_NUM; b++) begin : g_bank
    logic [31:0]   off, word;
    logic [IW-1:0] rd_idx;
    logic          wr_hit;
    assign off    = (32'(b) + BN - (32'(base) % BN)) % BN;
    assign word   = 32'(base) + off;
    assign rd_idx = IW'(word / BN);
    assign wr_hit = wr_act && (wr_bank == 32'(b));
    assign bram_wen[b]          = wr_hit;
    assign bram_addr[b*AW +: AW] = wr_hit ? {wr_region, wr_idx} : {rd_region, rd_idx};
  end

  // Output lane j carries logical word base+j, found in bank (base+j) mod BANK_NUM.
  for (genvar j = 0; j < BANK_NUM; j++) begin : g_lane
    logic [31:0]  lane_bank;
    logic [W-1:0] lane_data;
    assign lane_bank = (32'(j) + 32'(base_lo_p[READ_LATENCY-1])) % BN;
    // Bank-to-lane rotation mux.
    always_comb begin
      lane_data = '0;
      for (int b = 0; b < BANK_NUM; b++)
        if (lane_bank == 32'(b)) lane_data = bram_rdata[b*W +: W];
    end
    assign weight_out[j*W +: W] = weight_out_valid ? lane_data : '0;
  end

endmodule
